rv32_bus_fabric: RTL and testbench

Parametrised successor to the fixed four-way address arbiter in the SoC top level. It sits between the picorv32 native memory port and N memory-mapped slaves: BRAM, VGA, key input, seven-segment and future peripherals. It registers each CPU request and decodes the address against a per-slave range table. It runs one transaction at a time with a wait-state handshake, answers unmapped or hung accesses with an error word, and records the first fault in sticky status outputs.

---
 rtl/rv32_fabric_pkg.sv | 16 +
 rtl/rv32_addr_decode.sv | 23 ++
 rtl/rv32_bus_fabric.sv | 140 ++++++++++++++
 tb/tb_rv32_bus_fabric.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fabric_pkg.sv
// Shared types and constants for the rv32 bus fabric and its address decoder.
package rv32_fabric_pkg;

   typedef logic [1:0] fabric_state_t;

   localparam fabric_state_t ST_IDLE = 2'd0;
   localparam fabric_state_t ST_REQ  = 2'd1;
   localparam fabric_state_t ST_RESP = 2'd2;

   localparam logic FAULT_MISS    = 1'b0;
   localparam logic FAULT_TIMEOUT = 1'b1;

   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;
   localparam int          TIMEOUT_W         = 16;

endpackage

// File: rtl/rv32_addr_decode.sv
// Combinational range decoder: inclusive unsigned base/last compare, lowest slave index wins.
module rv32_addr_decode #(
   parameter int                     N_SLAVES    = 4,
   parameter logic [64*N_SLAVES-1:0] ADDR_RANGES = {N_SLAVES{64'h0}}
) (
   input  logic [31:0]         addr,
   output logic [N_SLAVES-1:0] sel,
   output logic                hit
);

   // Slave 0 owns the most-significant pair and select bit, so scan from the top bit down.
   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int j = N_SLAVES - 1; j >= 0; j--) begin
         if (!hit && (addr >= ADDR_RANGES[64*j+32 +: 32]) && (addr <= ADDR_RANGES[64*j +: 32])) begin
            sel[j] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rv32_bus_fabric.sv
// picorv32 native-port fabric: one registered transaction at a time to N range-decoded slaves.
// Optional feature macro RV32_FABRIC_TIMEOUT_EN builds the REQ timeout/abort path.
module rv32_bus_fabric
   import rv32_fabric_pkg::*;
#(
   parameter int                     N_SLAVES       = 4,
   parameter logic [64*N_SLAVES-1:0] ADDR_RANGES    = {N_SLAVES{64'h0}},
   parameter int                     TIMEOUT_CYCLES = 255,
   parameter logic [31:0]            ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   m_valid,
   output logic                   m_ready,
   input  logic [31:0]            m_addr,
   input  logic [31:0]            m_wdata,
   input  logic [3:0]             m_wstrb,
   output logic [31:0]            m_rdata,
   output logic [N_SLAVES-1:0]    s_valid,
   input  logic [N_SLAVES-1:0]    s_ready,
   input  logic [32*N_SLAVES-1:0] s_rdata,
   output logic [31:0]            s_addr,
   output logic [31:0]            s_wdata,
   output logic [3:0]             s_wstrb,
   output logic                   fault_valid,
   output logic                   fault_kind,
   output logic [31:0]            fault_addr,
   input  logic                   fault_clear
);

   fabric_state_t       state;
   logic [N_SLAVES-1:0] dec_sel;
   logic [N_SLAVES-1:0] sel_q;
   logic                dec_hit;
   logic                sel_ready;
   logic [31:0]         sel_rdata;
   logic                miss_hit;
   logic                timeout_hit;

   rv32_addr_decode #(
      .N_SLAVES    (N_SLAVES),
      .ADDR_RANGES (ADDR_RANGES)
   ) u_decode (
      .addr (m_addr),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   always_comb begin
      sel_rdata = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         if (sel_q[j]) sel_rdata = sel_rdata | s_rdata[32*j +: 32];
      end
   end

   assign sel_ready = |(s_ready & sel_q);
   assign s_valid   = (state == ST_REQ) ? sel_q : '0;
   assign m_ready   = (state == ST_RESP);
   assign miss_hit  = (state == ST_IDLE) && m_valid && !dec_hit;

`ifdef RV32_FABRIC_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 fault_kind_q;

   // The count would reach TIMEOUT_CYCLES on this edge; a simultaneous s_ready still wins.
   assign timeout_hit = (state == ST_REQ) && !sel_ready && (wait_cnt == TIMEOUT_LAST);
   assign fault_kind  = fault_kind_q;

   always_ff @(posedge clk) begin
      if (!reset_n || state != ST_REQ) wait_cnt <= '0;
      else if (!sel_ready)             wait_cnt <= wait_cnt + 1'b1;
   end
`else
   logic [TIMEOUT_W-1:0] unused_timeout_cfg;

   assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
   assign timeout_hit        = 1'b0;
   assign fault_kind         = FAULT_MISS;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         sel_q   <= '0;
         m_rdata <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_wstrb <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m_valid) begin
                  s_addr  <= m_addr;
                  s_wdata <= m_wdata;
                  s_wstrb <= m_wstrb;
                  sel_q   <= dec_sel;
                  if (dec_hit) begin
                     state <= ST_REQ;
                  end else begin
                     m_rdata <= ERR_RDATA;
                     state   <= ST_RESP;
                  end
               end
            end
            ST_REQ: begin
               if (sel_ready) begin
                  m_rdata <= sel_rdata;
                  state   <= ST_RESP;
               end else if (timeout_hit) begin
                  m_rdata <= ERR_RDATA;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A fault arriving with fault_clear is latched even if an older fault is still pending.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fault_valid <= 1'b0;
         fault_addr  <= '0;
`ifdef RV32_FABRIC_TIMEOUT_EN
         fault_kind_q <= FAULT_MISS;
`endif
      end else if ((miss_hit || timeout_hit) && (!fault_valid || fault_clear)) begin
         fault_valid <= 1'b1;
         fault_addr  <= miss_hit ? m_addr : s_addr;
`ifdef RV32_FABRIC_TIMEOUT_EN
         fault_kind_q <= miss_hit ? FAULT_MISS : FAULT_TIMEOUT;
`endif
      end else if (fault_clear) begin
         fault_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32_bus_fabric.sv
// Directed self-checking bench for rv32_bus_fabric; inputs change and outputs are sampled 1ns after each rising edge.
module tb_rv32_bus_fabric;

   logic         clk;
   logic         reset_n;
   logic         m_valid;
   logic         m_ready;
   logic [31:0]  m_addr;
   logic [31:0]  m_wdata;
   logic [3:0]   m_wstrb;
   logic [31:0]  m_rdata;
   logic [3:0]   s_valid;
   logic [3:0]   s_ready;
   logic [127:0] s_rdata;
   logic [31:0]  s_addr;
   logic [31:0]  s_wdata;
   logic [3:0]   s_wstrb;
   logic         fault_valid;
   logic         fault_kind;
   logic [31:0]  fault_addr;
   logic         fault_clear;

   int n_checks = 0;
   int n_fail   = 0;

   rv32_bus_fabric #(
      .N_SLAVES       (4),
      .ADDR_RANGES    ({32'h0000_0000, 32'h0000_FFFF,
                        32'h0000_0080, 32'h0001_0FFF,
                        32'h4000_0000, 32'h4000_FFFF,
                        32'hFFFF_0000, 32'hFFFF_FFFF}),
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (32'hDEADBEEF)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_rdata     (m_rdata),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_rdata     (s_rdata),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .fault_valid (fault_valid),
      .fault_kind  (fault_kind),
      .fault_addr  (fault_addr),
      .fault_clear (fault_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      m_valid = valid;
      m_addr  = addr;
      m_wdata = wdata;
      m_wstrb = wstrb;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      fault_clear = 1'b0;
      s_ready     = 4'b0000;
      s_rdata     = {32'h12345678, 32'h11111111, 32'hCAFEF00D, 32'h33333333};
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);

      // Reset values
      tick();
      tick();
      checkOutput("rst_m_ready", {31'b0, m_ready}, 32'd0);
      checkOutput("rst_s_valid", {28'b0, s_valid}, 32'd0);
      checkOutput("rst_m_rdata", m_rdata, 32'h0);
      checkOutput("rst_s_addr", s_addr, 32'h0);
      checkOutput("rst_s_wdata", s_wdata, 32'h0);
      checkOutput("rst_s_wstrb", {28'b0, s_wstrb}, 32'd0);
      checkOutput("rst_fault_valid", {31'b0, fault_valid}, 32'd0);
      checkOutput("rst_fault_kind", {31'b0, fault_kind}, 32'd0);
      checkOutput("rst_fault_addr", fault_addr, 32'h0);
      reset_n = 1'b1;
      tick();

      // Zero-wait read from slave 0
      applyStimulus(1'b1, 32'h0000_0010, 32'h0, 4'h0);
      s_ready = 4'b1000;
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("rd0_s_valid", {28'b0, s_valid}, 32'h8);
      checkOutput("rd0_m_ready_c1", {31'b0, m_ready}, 32'd0);
      checkOutput("rd0_s_addr", s_addr, 32'h0000_0010);
      tick();
      s_ready = 4'b0000;
      checkOutput("rd0_m_ready_c2", {31'b0, m_ready}, 32'd1);
      checkOutput("rd0_m_rdata", m_rdata, 32'h12345678);
      checkOutput("rd0_s_valid_c2", {28'b0, s_valid}, 32'h0);
      tick();
      checkOutput("rd0_m_ready_c3", {31'b0, m_ready}, 32'd0);

      // Write to slave 3 with 3 wait cycles; other slaves assert ready and must be ignored
      applyStimulus(1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 4'b0011);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("wr3_s_valid", {28'b0, s_valid}, 32'h1);
      s_ready = 4'b1110;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checkOutput("wr3_wait_s_valid", {28'b0, s_valid}, 32'h1);
         checkOutput("wr3_wait_m_ready", {31'b0, m_ready}, 32'd0);
         checkOutput("wr3_wait_s_wdata", s_wdata, 32'hA5A5_5A5A);
         checkOutput("wr3_wait_s_wstrb", {28'b0, s_wstrb}, 32'h3);
      end
      s_ready = 4'b0001;
      tick();
      s_ready = 4'b0000;
      checkOutput("wr3_m_ready", {31'b0, m_ready}, 32'd1);
      checkOutput("wr3_m_rdata", m_rdata, 32'h33333333);
      checkOutput("wr3_s_addr", s_addr, 32'hFFFF_FFFC);
      tick();
      checkOutput("wr3_m_ready_once", {31'b0, m_ready}, 32'd0);

      // Decode miss, then a second miss that must not overwrite the fault address
      applyStimulus(1'b1, 32'h0002_0000, 32'h0, 4'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("miss_m_ready", {31'b0, m_ready}, 32'd1);
      checkOutput("miss_m_rdata", m_rdata, 32'hDEADBEEF);
      checkOutput("miss_s_valid", {28'b0, s_valid}, 32'h0);
      checkOutput("miss_fault_valid", {31'b0, fault_valid}, 32'd1);
      checkOutput("miss_fault_kind", {31'b0, fault_kind}, 32'd0);
      checkOutput("miss_fault_addr", fault_addr, 32'h0002_0000);
      tick();
      applyStimulus(1'b1, 32'h0003_0000, 32'h0, 4'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("miss2_m_ready", {31'b0, m_ready}, 32'd1);
      checkOutput("miss2_fault_addr", fault_addr, 32'h0002_0000);
      tick();

      // Overlapping ranges: 0x90 is in slave 0 and slave 1, slave 0 wins
      applyStimulus(1'b1, 32'h0000_0090, 32'h0, 4'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("ovl_s_valid", {28'b0, s_valid}, 32'h8);
      s_ready = 4'b1000;
      tick();
      s_ready = 4'b0000;
      checkOutput("ovl_m_rdata", m_rdata, 32'h12345678);
      tick();

      // fault_clear coincident with a new miss latches the new fault
      applyStimulus(1'b1, 32'h0005_0000, 32'h0, 4'h0);
      fault_clear = 1'b1;
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("clrmiss_fault_valid", {31'b0, fault_valid}, 32'd1);
      checkOutput("clrmiss_fault_addr", fault_addr, 32'h0005_0000);
      tick();
      fault_clear = 1'b0;
      checkOutput("clr_fault_valid", {31'b0, fault_valid}, 32'd0);

`ifdef RV32_FABRIC_TIMEOUT_EN
      // Slave 1 never ready: s_valid high for exactly 8 REQ cycles, then error response
      applyStimulus(1'b1, 32'h0001_0000, 32'h0, 4'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("to_s_valid_c1", {28'b0, s_valid}, 32'h4);
      for (int k = 2; k <= 8; k++) begin
         tick();
         checkOutput("to_s_valid_wait", {28'b0, s_valid}, 32'h4);
      end
      tick();
      checkOutput("to_s_valid_drop", {28'b0, s_valid}, 32'h0);
      checkOutput("to_m_ready", {31'b0, m_ready}, 32'd1);
      checkOutput("to_m_rdata", m_rdata, 32'hDEADBEEF);
      checkOutput("to_fault_valid", {31'b0, fault_valid}, 32'd1);
      checkOutput("to_fault_kind", {31'b0, fault_kind}, 32'd1);
      checkOutput("to_fault_addr", fault_addr, 32'h0001_0000);
      tick();
`endif

      // Reset in REQ aborts silently; a later transaction completes normally
      applyStimulus(1'b1, 32'h0000_0010, 32'h0, 4'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("abort_s_valid_req", {28'b0, s_valid}, 32'h8);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checkOutput("abort_s_valid", {28'b0, s_valid}, 32'h0);
      checkOutput("abort_m_ready", {31'b0, m_ready}, 32'd0);
      checkOutput("abort_s_addr", s_addr, 32'h0);
      checkOutput("abort_m_rdata", m_rdata, 32'h0);
      checkOutput("abort_fault_valid", {31'b0, fault_valid}, 32'd0);
      tick();
      checkOutput("abort_m_ready_after", {31'b0, m_ready}, 32'd0);
      applyStimulus(1'b1, 32'h4000_0004, 32'h0, 4'h0);
      s_ready = 4'b0010;
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("post_s_valid", {28'b0, s_valid}, 32'h2);
      tick();
      s_ready = 4'b0000;
      checkOutput("post_m_ready", {31'b0, m_ready}, 32'd1);
      checkOutput("post_m_rdata", m_rdata, 32'hCAFEF00D);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
